pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 137 +++++++++++++
 tb/tb_pipe_control.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipeline control unit: decodes the ID-stage opcode into WB/M/EXE controls,
// carries them down ID/EX -> EX/MEM -> MEM/WB, and resolves load-use, branch and jump hazards.
module pipe_control #(
    parameter int OP_W  = 3,
    parameter int REG_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic [5:0]       ex_bundle,
    output logic [3:0]       mem_bundle,
    output logic [1:0]       wb_bundle,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] OP_LI   = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_SLTI = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_JUMP = 3'd7;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // Opcodes above 7 only exist for wider OP_W; they decode as NOP.
    logic op_high;
    generate
        if (OP_W > 3) begin : g_wide_op
            assign op_high = |op[OP_W-1:3];
        end else begin : g_narrow_op
            assign op_high = 1'b0;
        end
    endgenerate

    logic [2:0] opc;
    logic       is_li, is_lw, is_sw, is_addi, is_beq, is_slti, is_add, is_jump;
    logic       alusrc, memtoreg, regwrite, memread, memwrite;
    logic [5:0] dec_bundle;

    assign opc     = op[2:0];
    assign is_li   = ~op_high & (opc == OP_LI);
    assign is_lw   = ~op_high & (opc == OP_LW);
    assign is_sw   = ~op_high & (opc == OP_SW);
    assign is_addi = ~op_high & (opc == OP_ADDI);
    assign is_beq  = ~op_high & (opc == OP_BEQ);
    assign is_slti = ~op_high & (opc == OP_SLTI);
    assign is_add  = ~op_high & (opc == OP_ADD);
    assign is_jump = ~op_high & (opc == OP_JUMP);

    assign alusrc     = is_li | is_lw | is_sw | is_addi | is_slti;
    assign memtoreg   = is_lw | is_sw;
    assign regwrite   = is_li | is_lw | is_addi | is_slti | is_add;
    assign memread    = is_lw;
    assign memwrite   = is_sw;
    assign dec_bundle = {memtoreg, regwrite, memread, memwrite, alusrc, is_li};

    logic [5:0]       idex_bundle_reg;
    logic             idex_branch_reg;
    logic [REG_W-1:0] idex_rd_reg;
    logic [3:0]       exmem_bundle_reg;
    logic [1:0]       memwb_bundle_reg;

    logic       taken, uses_src, load_use;
    logic       stall_int, jump_int, bubble;
    logic [5:0] idex_bundle_next;
    logic       idex_branch_next;
    logic [REG_W-1:0] idex_rd_next;

    // li and jump read no source registers, so they never wait on a load.
    assign uses_src  = id_valid & ~(is_li | is_jump | op_high);
    assign taken     = idex_branch_reg & ex_zero;
    assign load_use  = idex_bundle_reg[3] & uses_src &
                       ((idex_rd_reg == id_rs) | (idex_rd_reg == id_rt));
    assign stall_int = load_use & ~taken;
    assign jump_int  = id_valid & is_jump & ~taken;
    assign bubble    = ~id_valid | taken | stall_int | jump_int;

    assign idex_bundle_next = bubble ? 6'd0 : dec_bundle;
    assign idex_branch_next = bubble ? 1'b0 : is_beq;
    assign idex_rd_next     = bubble ? '0 : id_rd;

    // Gated with rst_n so a decode-stage jump cannot redirect fetch during reset.
    assign stall  = rst_n & stall_int;
    assign flush  = rst_n & (taken | jump_int);
    assign pc_sel = ~rst_n   ? PC_SEQ    :
                    taken    ? PC_BRANCH :
                    jump_int ? PC_JUMP   : PC_SEQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_bundle_reg  <= 6'd0;
            idex_branch_reg  <= 1'b0;
            idex_rd_reg      <= '0;
            exmem_bundle_reg <= 4'd0;
            memwb_bundle_reg <= 2'd0;
        end else begin
            idex_bundle_reg  <= idex_bundle_next;
            idex_branch_reg  <= idex_branch_next;
            idex_rd_reg      <= idex_rd_next;
            exmem_bundle_reg <= idex_bundle_reg[5:2];
            memwb_bundle_reg <= exmem_bundle_reg[3:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign ex_bundle  = idex_bundle_reg;
    assign mem_bundle = exmem_bundle_reg;
    assign wb_bundle  = memwb_bundle_reg;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed literal scenarios plus randomized traffic checked
// every cycle against an instruction-level model of the pipeline.
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] op;
    logic       id_valid;
    logic [1:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic [5:0] ex_bundle;
    logic [3:0] mem_bundle;
    logic [1:0] wb_bundle;
    logic       stall, flush;
    logic [1:0] pc_sel;
    logic [7:0] stall_cnt, flush_cnt;

    logic [3:0] op2;
    logic       valid2;
    logic [1:0] rs2, rt2, rd2;
    logic       zero2;
    logic [5:0] ex2;
    logic [3:0] mem2;
    logic [1:0] wb2;
    logic       st2, fl2;
    logic [1:0] ps2;
    logic [1:0] sc2, fc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_bundle(ex_bundle), .mem_bundle(mem_bundle), .wb_bundle(wb_bundle),
        .stall(stall), .flush(flush), .pc_sel(pc_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_control #(.OP_W(4), .REG_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op2), .id_valid(valid2),
        .id_rs(rs2), .id_rt(rt2), .id_rd(rd2), .ex_zero(zero2),
        .ex_bundle(ex2), .mem_bundle(mem2), .wb_bundle(wb2),
        .stall(st2), .flush(fl2), .pc_sel(ps2),
        .stall_cnt(sc2), .flush_cnt(fc2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [1:0] s,
                         input logic [1:0] t, input logic [1:0] d);
        id_valid = v; op = o; id_rs = s; id_rt = t; id_rd = d;
        $display("txn t=%0t valid=%0d op=%0d rs=%0d rt=%0d rd=%0d rst_n=%0d",
                 $time, v, o, s, t, d, rst_n);
    endtask

    task automatic idle();
        id_valid = 1'b0; op = 3'd0; id_rs = 2'd0; id_rt = 2'd0; id_rd = 2'd0; ex_zero = 1'b0;
    endtask

    task automatic drive2(input logic v, input logic [3:0] o, input logic [1:0] s,
                          input logic [1:0] t, input logic [1:0] d);
        valid2 = v; op2 = o; rs2 = s; rt2 = t; rd2 = d;
        $display("txn2 t=%0t valid=%0d op=%0d rs=%0d rt=%0d rd=%0d", $time, v, o, s, t, d);
    endtask

    task automatic idle2();
        valid2 = 1'b0; op2 = 4'd0; rs2 = 2'd0; rt2 = 2'd0; rd2 = 2'd0; zero2 = 1'b0;
    endtask

    // Control bundle of an instruction, straight from the opcode's meaning; -1 is a bubble.
    function automatic logic [5:0] bundle_of(input int o);
        logic li, lw, sw, addi, slti, add;
        li = (o == 0); lw = (o == 1); sw = (o == 2); addi = (o == 3);
        slti = (o == 5); add = (o == 6);
        return {lw | sw, li | lw | addi | slti | add, lw, sw,
                li | lw | sw | addi | slti, li};
    endfunction

    // Instruction-level model: which instruction occupies EX, MEM and WB.
    int         m_ex = -1, m_mem = -1, m_wb = -1;
    logic [1:0] m_ex_rd = 2'd0;
    int         m_sc = 0, m_fc = 0;
    int         n_ex;
    logic [1:0] n_rd;
    bit         e_taken, e_lu, e_stall, e_jump;
    int         e_pc;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            m_ex = -1; m_mem = -1; m_wb = -1; m_sc = 0; m_fc = 0;
            check("rst_ex_bundle", 32'(ex_bundle), 32'd0);
            check("rst_mem_bundle", 32'(mem_bundle), 32'd0);
            check("rst_wb_bundle", 32'(wb_bundle), 32'd0);
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_flush", 32'(flush), 32'd0);
            check("rst_pc_sel", 32'(pc_sel), 32'd0);
            check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
            check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        end else begin
            e_taken = (m_ex == 4) && ex_zero;
            e_lu    = id_valid && (m_ex == 1) && ((m_ex_rd == id_rs) || (m_ex_rd == id_rt))
                      && (op != 3'd0) && (op != 3'd7);
            e_stall = e_lu && !e_taken;
            e_jump  = id_valid && (op == 3'd7) && !e_taken;
            e_pc    = e_taken ? 1 : (e_jump ? 2 : 0);
            check("m_ex_bundle", 32'(ex_bundle), 32'(bundle_of(m_ex)));
            check("m_mem_bundle", 32'(mem_bundle), 32'(bundle_of(m_mem) >> 2));
            check("m_wb_bundle", 32'(wb_bundle), 32'(bundle_of(m_wb) >> 4));
            check("m_stall", 32'(stall), 32'(e_stall));
            check("m_flush", 32'(flush), 32'(e_taken || e_jump));
            check("m_pc_sel", 32'(pc_sel), 32'(e_pc));
            check("m_stall_cnt", 32'(stall_cnt), 32'((m_sc > 255) ? 255 : m_sc));
            check("m_flush_cnt", 32'(flush_cnt), 32'((m_fc > 255) ? 255 : m_fc));
            n_ex = (id_valid && !e_taken && !e_stall && !e_jump) ? int'(op) : -1;
            n_rd = id_rd;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_ex = -1; m_mem = -1; m_wb = -1; m_sc = 0; m_fc = 0;
        end else begin
            m_wb = m_mem; m_mem = m_ex; m_ex = n_ex; m_ex_rd = n_rd;
            if (e_stall) m_sc++;
            if (e_taken || e_jump) m_fc++;
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        idle2();
        repeat (2) step();
        #1;
        check("reset_ex", 32'(ex_bundle), 32'd0);
        check("reset_pc_sel", 32'(pc_sel), 32'd0);
        step();
        rst_n = 1'b1;

        // lw travels through the stages
        drive(1, 3'd1, 2'd0, 2'd1, 2'd3);
        #1 check("lw_no_stall", 32'(stall), 32'd0);
        step(); idle();
        #1 check("lw_ex", 32'(ex_bundle), 32'(6'b111010));
        step();
        #1 check("lw_mem", 32'(mem_bundle), 32'(4'b1110));
        step();
        #1 check("lw_wb", 32'(wb_bundle), 32'(2'b11));

        // load-use stall
        step(); drive(1, 3'd1, 2'd0, 2'd0, 2'd2);
        step(); drive(1, 3'd6, 2'd2, 2'd1, 2'd3);
        #1 check("lu_stall", 32'(stall), 32'd1);
        step();
        #1 check("lu_bubble", 32'(ex_bundle), 32'd0);
        check("lu_stall_once", 32'(stall), 32'd0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step(); idle();
        #1 check("lu_add_ex", 32'(ex_bundle), 32'(6'b010000));

        // taken branch, then not-taken branch
        step(); drive(1, 3'd4, 2'd0, 2'd0, 2'd0);
        step(); drive(1, 3'd6, 2'd0, 2'd0, 2'd1); ex_zero = 1'b1;
        #1 check("br_pc_sel", 32'(pc_sel), 32'd1);
        check("br_flush", 32'(flush), 32'd1);
        step(); drive(1, 3'd4, 2'd0, 2'd0, 2'd0); ex_zero = 1'b0;
        #1 check("br_squash", 32'(ex_bundle), 32'd0);
        step(); drive(1, 3'd6, 2'd0, 2'd0, 2'd1); ex_zero = 1'b0;
        #1 check("bnt_pc_sel", 32'(pc_sel), 32'd0);
        check("bnt_flush", 32'(flush), 32'd0);
        step(); idle();
        #1 check("bnt_add_ex", 32'(ex_bundle), 32'(6'b010000));

        // jump
        step(); drive(1, 3'd7, 2'd0, 2'd0, 2'd0);
        #1 check("jmp_pc_sel", 32'(pc_sel), 32'd2);
        check("jmp_flush", 32'(flush), 32'd1);
        step(); idle();
        #1 check("jmp_ex", 32'(ex_bundle), 32'd0);
        check("jmp_flush_cnt", 32'(flush_cnt), 32'd2);

        // taken branch beats a decode jump
        step(); drive(1, 3'd4, 2'd0, 2'd0, 2'd0);
        step(); drive(1, 3'd7, 2'd0, 2'd0, 2'd0); ex_zero = 1'b1;
        #1 check("prio_pc_sel", 32'(pc_sel), 32'd1);
        check("prio_flush", 32'(flush), 32'd1);
        check("prio_stall", 32'(stall), 32'd0);
        step(); idle();
        #1 check("prio_flush_cnt", 32'(flush_cnt), 32'd3);

        // reset in the middle of li, lw, add
        step(); drive(1, 3'd0, 2'd0, 2'd0, 2'd1);
        step(); drive(1, 3'd1, 2'd0, 2'd0, 2'd2);
        step(); drive(1, 3'd6, 2'd2, 2'd0, 2'd3);
        #1 check("mid_stall", 32'(stall), 32'd1);
        check("mid_mem", 32'(mem_bundle), 32'(4'b0100));
        rst_n = 1'b0;
        #1 check("mid_rst_ex", 32'(ex_bundle), 32'd0);
        check("mid_rst_mem", 32'(mem_bundle), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_scnt", 32'(stall_cnt), 32'd0);
        check("mid_rst_fcnt", 32'(flush_cnt), 32'd0);
        step(); drive(1, 3'd7, 2'd0, 2'd0, 2'd0);
        #1 check("rst_jmp_flush", 32'(flush), 32'd0);
        check("rst_jmp_pc_sel", 32'(pc_sel), 32'd0);
        step(); rst_n = 1'b1; drive(1, 3'd6, 2'd2, 2'd0, 2'd3);
        #1 check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_flush", 32'(flush), 32'd0);
        step(); idle();
        #1 check("post_rst_ex", 32'(ex_bundle), 32'(6'b010000));

        // narrow counter saturates after five load-use stalls
        for (int k = 0; k < 5; k++) begin
            step(); drive2(1, 4'd1, 2'd0, 2'd0, 2'd1);
            step(); drive2(1, 4'd6, 2'd1, 2'd0, 2'd2);
            #1 check("d2_stall", 32'(st2), 32'd1);
            check("d2_flush", 32'(fl2), 32'd0);
            step();
        end
        step(); idle2();
        #1 check("d2_stall_cnt_sat", 32'(sc2), 32'd3);

        // op above 7 is a NOP and never stalls
        step(); drive2(1, 4'd1, 2'd0, 2'd0, 2'd1);
        step(); drive2(1, 4'd9, 2'd1, 2'd1, 2'd0);
        #1 check("d2_lw_ex", 32'(ex2), 32'(6'b111010));
        check("d2_nop_stall", 32'(st2), 32'd0);
        step(); idle2();
        #1 check("d2_nop_ex", 32'(ex2), 32'd0);
        check("d2_mem", 32'(mem2), 32'(4'b1110));
        check("d2_pc_sel", 32'(ps2), 32'd0);
        step();
        #1 check("d2_wb", 32'(wb2), 32'(2'b11));
        check("d2_flush_cnt", 32'(fc2), 32'd0);

        // randomized traffic with occasional reset pulses
        for (int i = 0; i < 600; i++) begin
            step();
            rst_n = ($urandom_range(0, 59) != 0);
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            ex_zero = 1'($urandom_range(0, 1));
        end
        step(); rst_n = 1'b1; idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
